// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM encodings,
// operation-mode codes and the step-counter width helper.
package serial_adder_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int cnt_width(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; chained DIGIT times to form one serial step.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor consuming DIGIT bits per clock,
// with a START/BUSY/DONE handshake and registered SUM/COUT/OVF results.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             msba_r;
    logic             msbb_r;

    logic             load_s;
    logic             step_s;
    logic             finish_s;
    logic             last_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             cin_eff_s;
    logic [DIGIT:0]   chain_s;
    logic [DIGIT-1:0] dsum_s;
    logic [WIDTH-1:0] acc_next_s;
    logic             ovf_s;

    // Subtraction is A + ~B + ~CIN, so the borrow-in is inverted into a carry.
    always_comb begin
        b_eff_s   = b;
        cin_eff_s = cin;
        case (mode)
            MODE_ADD: begin
                b_eff_s   = b;
                cin_eff_s = cin;
            end
            MODE_SUB: begin
                b_eff_s   = ~b;
                cin_eff_s = ~cin;
            end
            default: begin
                b_eff_s   = b;
                cin_eff_s = cin;
            end
        endcase
    end

    assign chain_s[0] = carry_r;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a    (opa_r[i]),
            .b    (opb_r[i]),
            .cin  (chain_s[i]),
            .sum  (dsum_s[i]),
            .cout (chain_s[i+1])
        );
    end

    // New digit enters at the MSB end so the first digit ends up at bit 0.
    assign acc_next_s = (acc_r >> DIGIT) | (WIDTH'(dsum_s) << (WIDTH - DIGIT));
    assign last_s     = (cnt_r == CW'(STEPS - 1));
    assign ovf_s      = (msba_r == msbb_r) && (acc_next_s[WIDTH-1] != msba_r);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s       = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    finish_s     = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, per-step shifting and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            msba_r  <= 1'b0;
            msbb_r  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= finish_s;
            if (load_s) begin
                opa_r   <= a;
                opb_r   <= b_eff_s;
                carry_r <= cin_eff_s;
                msba_r  <= a[WIDTH-1];
                msbb_r  <= b_eff_s[WIDTH-1];
                acc_r   <= {WIDTH{1'b0}};
                cnt_r   <= {CW{1'b0}};
                busy    <= 1'b1;
            end else if (step_s) begin
                opa_r   <= opa_r >> DIGIT;
                opb_r   <= opb_r >> DIGIT;
                carry_r <= chain_s[DIGIT];
                acc_r   <= acc_next_s;
                if (finish_s) begin
                    cnt_r <= {CW{1'b0}};
                    busy  <= 1'b0;
                    sum   <= acc_next_s;
                    cout  <= chain_s[DIGIT];
                    ovf   <= ovf_s;
                end else begin
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule
